// File: rtl/ptw_mem_responder.sv
// Serves page-table-walker PTE reads over the data bus: IDLE -> REQ -> WAIT -> RESP -> GAP.
// Define PTW_PTE_CACHE_EN to add a 4-entry direct-mapped PTE cache in front of the bus.
module ptw_mem_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic [63:0] mem_addr,
  output logic [63:0] pte,
  output logic        pte_valid,
  output logic        bus_valid,
  output logic [63:0] bus_addr,
  output logic [2:0]  bus_size,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [63:0] bus_data,
  input  logic        flush,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, GAP} state_t;

  state_t      state;
  logic        dropped;
  logic        in_flight;
  logic        data_done;
  logic        keep;
  logic        hit;
  logic [63:0] hit_pte;

  assign bus_size  = 3'd3;
  assign busy      = (state != IDLE);
  assign in_flight = (state == REQ) || (state == WAIT);
  assign data_done = bus_data_ok && ((state == WAIT) || ((state == REQ) && bus_addr_ok));
  // A walker that lets go of mem_req mid-transaction no longer wants the result.
  assign keep      = mem_req && !dropped;

`ifdef PTW_PTE_CACHE_EN
  logic [3:0]  cache_vld;
  logic [58:0] cache_tag [4];
  logic [63:0] cache_pte [4];
  logic        stale;
  logic        fill;
  logic [1:0]  idx;
  logic [1:0]  fill_idx;

  assign idx      = mem_addr[4:3];
  assign fill_idx = bus_addr[4:3];
  assign hit      = cache_vld[idx] && (cache_tag[idx] == mem_addr[63:5]) && !flush;
  assign hit_pte  = cache_pte[idx];
  // Data fetched across a flush may belong to the old translation; never cache it.
  assign fill     = data_done && keep && !stale && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_vld <= '0;
      stale     <= 1'b0;
    end else begin
      if ((state == IDLE) && mem_req)
        stale <= 1'b0;
      else if (flush && in_flight)
        stale <= 1'b1;
      if (flush)
        cache_vld <= '0;
      else if (fill)
        cache_vld[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      cache_tag[fill_idx] <= bus_addr[63:5];
      cache_pte[fill_idx] <= bus_data;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign hit          = 1'b0;
  assign hit_pte      = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pte       <= '0;
      pte_valid <= 1'b0;
      bus_valid <= 1'b0;
      bus_addr  <= '0;
      dropped   <= 1'b0;
    end else begin
      pte_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            dropped <= 1'b0;
            if (mem_addr[2:0] != 3'd0) begin
              pte       <= '0;
              pte_valid <= 1'b1;
              state     <= RESP;
            end else if (hit) begin
              pte       <= hit_pte;
              pte_valid <= 1'b1;
              state     <= RESP;
            end else begin
              bus_addr  <= mem_addr;
              bus_valid <= 1'b1;
              state     <= REQ;
            end
          end
        end
        REQ, WAIT: begin
          if (!mem_req)
            dropped <= 1'b1;
          if ((state == REQ) && bus_addr_ok) begin
            bus_valid <= 1'b0;
            state     <= WAIT;
          end
          if (data_done) begin
            state <= RESP;
            if (keep) begin
              pte       <= bus_data;
              pte_valid <= 1'b1;
            end
          end
        end
        RESP:    state <= GAP;
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ptw_mem_responder.sv
// Randomized bench for ptw_mem_responder with a transaction-level walker/bus/cache model.
module tb_ptw_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [63:0] pte;
  logic        pte_valid;
  logic        bus_valid;
  logic [63:0] bus_addr;
  logic [2:0]  bus_size;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [63:0] bus_data;
  logic        flush;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int req_id = 0;

`ifdef PTW_PTE_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  // Cache contents as address -> PTE; a fill evicts whatever shares its index bits.
  logic [63:0] mcache [logic [63:0]];

  ptw_mem_responder dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .pte(pte), .pte_valid(pte_valid), .bus_valid(bus_valid), .bus_addr(bus_addr),
    .bus_size(bus_size), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_data(bus_data), .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (req %0d): got 0x%0h, expected 0x%0h", tag, req_id, got, exp);
    end
  endtask

  function automatic void m_flush();
    if (CACHE_EN) mcache.delete();
  endfunction

  function automatic void m_fill(input logic [63:0] a, input logic [63:0] d);
    logic [63:0] victims[$];
    if (!CACHE_EN) return;
    foreach (mcache[k]) if (k[4:3] == a[4:3]) victims.push_back(k);
    foreach (victims[i]) mcache.delete(victims[i]);
    mcache[a] = d;
  endfunction

  // Called #1 after a clock edge with the DUT idle. Acts as both walker and bus.
  task automatic run_req(input logic [63:0] addr, input int a_lat, input int d_lat,
                         input logic [63:0] data, input bit drop, input bit fl_mid,
                         input bit fl_first);
    int n, vcnt, pcnt, pv_n, idle_n, acc_n, exp_pv_n;
    bit misal, exp_hit, exp_bus, drop_eff, flm, stable, accepted;
    logic [63:0] got_pte, got_addr, exp_pte;

    req_id++;
    if (fl_first) m_flush();
    misal    = (addr[2:0] != 3'd0);
    exp_hit  = !misal && mcache.exists(addr);
    exp_bus  = !misal && !exp_hit;
    exp_pte  = misal ? 64'd0 : (exp_hit ? mcache[addr] : data);
    drop_eff = drop && exp_bus && (d_lat >= 1);
    flm      = fl_mid && exp_bus && (d_lat >= 1);
    exp_pv_n = exp_bus ? (2 + a_lat + d_lat) : 1;

    mem_req  = 1'b1;
    mem_addr = addr;
    flush    = fl_first;
    n = 0; vcnt = 0; pcnt = 0; pv_n = -1; idle_n = -1; acc_n = -1;
    stable = 1'b1; accepted = 1'b0; got_pte = '0; got_addr = '0;

    while (idle_n < 0 && n < 80) begin
      @(posedge clk); #1;
      n++;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_data    = {$urandom, $urandom};
      flush       = 1'b0;
      if (pte_valid) begin
        pcnt++;
        pv_n    = n;
        got_pte = pte;
      end
      if (!busy) begin
        idle_n = n;
      end else begin
        if (bus_valid) begin
          if (vcnt == 0) got_addr = bus_addr;
          else if (bus_addr != got_addr) stable = 1'b0;
          if (vcnt == a_lat) begin
            bus_addr_ok = 1'b1;
            accepted    = 1'b1;
            acc_n       = n;
          end
          vcnt++;
        end
        if (accepted && n == acc_n + d_lat) begin
          bus_data_ok = 1'b1;
          bus_data    = data;
        end
        if (accepted && n == acc_n + 1) begin
          if (drop_eff) mem_req = 1'b0;
          if (flm) flush = 1'b1;
        end
        // Stray data strobes once the response is out must be ignored.
        if (pcnt > 0) bus_data_ok = 1'($urandom_range(0, 1));
      end
    end

    check("pv_count", pcnt, drop_eff ? 0 : 1);
    if (!drop_eff) begin
      check("pv_cycle", pv_n, exp_pv_n);
      check("pte", got_pte, exp_pte);
    end
    check("bus_cycles", vcnt, exp_bus ? (a_lat + 1) : 0);
    if (exp_bus) begin
      check("bus_addr", got_addr, addr);
      check("addr_stable", stable, 1);
    end
    check("idle_cycle", idle_n, exp_pv_n + 2);

    if (flm) m_flush();
    else if (exp_bus && !drop_eff) m_fill(addr, data);
  endtask

  task automatic flush_pulse();
    mem_req = 1'b0;
    flush   = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    m_flush();
  endtask

  initial begin
    int n, npv;
    logic [63:0] a;
    reset = 1'b1; mem_req = 1'b0; mem_addr = '0; bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0; bus_data = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pte", pte, 0);
    check("rst_pte_valid", pte_valid, 0);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_busy", busy, 0);
    check("bus_size", bus_size, 3);
    reset = 1'b0;

    // Directed scenarios.
    run_req(64'h8000_1008, 2, 3, 64'h2000_0401, 0, 0, 0);
    run_req(64'h8000_2000, 0, 0, 64'hCF, 0, 0, 0);
    run_req(64'h8000_1004, 1, 1, 64'h55, 0, 0, 0);
    flush_pulse();
    run_req(64'h8000_1008, 1, 2, 64'h11, 0, 0, 0);
    run_req(64'h8000_1008, 1, 2, 64'h99, 0, 0, 0);
    flush_pulse();
    run_req(64'h8000_1008, 1, 1, 64'h12, 0, 0, 0);
    run_req(64'h8000_1008, 0, 1, 64'h13, 0, 0, 1);
    run_req(64'h8000_4010, 1, 3, 64'h77, 1, 0, 0);
    run_req(64'h8000_4010, 0, 2, 64'h78, 0, 1, 0);
    run_req(64'h8000_4010, 0, 1, 64'h79, 0, 0, 0);

    // Reset in WAIT, then a stray data strobe.
    flush_pulse();
    mem_req = 1'b1; mem_addr = 64'h8000_3F18;
    n = 0;
    while (!bus_valid && n < 10) begin @(posedge clk); #1; n++; end
    check("rst_mid_req", bus_valid, 1);
    bus_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus_addr_ok = 1'b0;
    check("rst_mid_wait", busy, 1);
    reset = 1'b1; mem_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_flush();
    npv = 0;
    bus_data_ok = 1'b1; bus_data = 64'hDEAD_BEEF;
    repeat (3) begin @(posedge clk); #1; if (pte_valid) npv++; end
    bus_data_ok = 1'b0;
    check("rst_mid_pv", npv, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_pte", pte, 0);
    check("rst_mid_bus_valid", bus_valid, 0);

    // Three-level walk with mem_req held throughout.
    run_req(64'h8000_0000, 1, 1, 64'h2000_1001, 0, 0, 0);
    run_req(64'h8000_4008, 0, 2, 64'h2000_2001, 0, 0, 0);
    run_req(64'h8000_8010, 2, 0, 64'h2000_30CF, 0, 0, 0);

    // Random traffic over a small address pool so hits and evictions occur.
    for (int i = 0; i < 60; i++) begin
      a = 64'h8000_0000 + (64'($urandom_range(0, 3)) << 5) + (64'($urandom_range(0, 3)) << 3);
      if ($urandom_range(0, 7) == 0) a = a + 64'($urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0) flush_pulse();
      run_req(a, $urandom_range(0, 4), $urandom_range(0, 5), {$urandom, $urandom},
              $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
